aes_enc_round_datapath: RTL and testbench

AES_ENC_ROUND_DATAPATH -- requirements
Module: aes_enc_round_datapath

---
 rtl/aes_enc_round_datapath_if.sv | 25 ++
 rtl/aes_enc_round_datapath.sv | 77 +++++++
 tb/tb_aes_enc_round_datapath.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/aes_enc_round_datapath_if.sv
// Register-bus write port of the AES round datapath.
// The master drives address and word; the slave returns the split paths.
interface aes_enc_round_datapath_if #(
   parameter int NFLAGS = 8,
   parameter int WORD_W = 32
);
   logic              addr;
   logic [WORD_W-1:0] inp_demux;
   logic [NFLAGS-1:0] outp_flags;
   logic [WORD_W-1:0] outp_data;

   modport master (
      output addr,
      output inp_demux,
      input  outp_flags,
      input  outp_data
   );

   modport slave (
      input  addr,
      input  inp_demux,
      output outp_flags,
      output outp_data
   );
endinterface

// File: rtl/aes_enc_round_datapath.sv
// AES encryption round helpers: bus demux, AddRoundKey, MixColumns.
// The three paths are fully independent of each other.
module aes_enc_round_datapath #(
   parameter int NFLAGS = 8,
   parameter int WORD_W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   aes_enc_round_datapath_if.slave bus,
   input  logic [127:0] inp_addRK,
   input  logic [127:0] inp_key,
   output logic [127:0] outp_addRK,
   input  logic [127:0] inp_mC,
   input  logic         wr_en_mC,
   output logic [127:0] outp_mC
);

   function automatic logic [7:0] xtime(input logic [7:0] x);
      logic [7:0] r;
      r = {x[6:0], 1'b0};
      if (x[7]) r = r ^ 8'h1B;
      return r;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      logic [7:0] d0, d1, d2, d3;
      s0 = c[7:0];
      s1 = c[15:8];
      s2 = c[23:16];
      s3 = c[31:24];
      d0 = xtime(s0);
      d1 = xtime(s1);
      d2 = xtime(s2);
      d3 = xtime(s3);
      return {
         (d0 ^ s0) ^ s1 ^ s2 ^ d3,
         s0 ^ s1 ^ d2 ^ (d3 ^ s3),
         s0 ^ d1 ^ (d2 ^ s2) ^ s3,
         d0 ^ (d1 ^ s1) ^ s2 ^ s3
      };
   endfunction

   logic [127:0] mc_next;

   // Route the bus word to the flag path or the data path by address.
   always_comb begin
      bus.outp_flags = '0;
      bus.outp_data  = '0;
      unique case (bus.addr)
         1'b0: bus.outp_flags = bus.inp_demux[NFLAGS-1:0];
         1'b1: bus.outp_data  = bus.inp_demux;
         default: ;
      endcase
   end

   // Four independent column mixers, all combinational.
   always_comb begin
      mc_next = '0;
      for (int c = 0; c < 4; c++) begin
         mc_next[32*c +: 32] = mix_col(inp_mC[32*c +: 32]);
      end
   end

   // AddRoundKey result register, updated every cycle.
   always_ff @(posedge clk) begin
      if (!resetn) outp_addRK <= '0;
      else         outp_addRK <= inp_addRK ^ inp_key;
   end

   // MixColumns result register, loaded only when enabled.
   always_ff @(posedge clk) begin
      if (!resetn)       outp_mC <= '0;
      else if (wr_en_mC) outp_mC <= mc_next;
   end

endmodule

// File: tb/tb_aes_enc_round_datapath.sv
// Self-checking bench for aes_enc_round_datapath.
// Random traffic is compared with a GF(2^8) matrix-multiply model.
module tb_aes_enc_round_datapath;
   localparam int NFLAGS = 8;
   localparam int WORD_W = 32;

   logic         clk = 1'b0;
   logic         resetn;
   logic [127:0] inp_addRK, inp_key, outp_addRK;
   logic [127:0] inp_mC, outp_mC;
   logic         wr_en_mC;

   int checks = 0;
   int errors = 0;

   aes_enc_round_datapath_if #(.NFLAGS(NFLAGS), .WORD_W(WORD_W)) bus ();

   aes_enc_round_datapath #(.NFLAGS(NFLAGS), .WORD_W(WORD_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus.slave),
      .inp_addRK  (inp_addRK),
      .inp_key    (inp_key),
      .outp_addRK (outp_addRK),
      .inp_mC     (inp_mC),
      .wr_en_mC   (wr_en_mC),
      .outp_mC    (outp_mC)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1B;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [127:0] mix_ref(input logic [127:0] s);
      logic [7:0]   circ [4];
      logic [127:0] r;
      logic [7:0]   acc;
      circ[0] = 8'd2; circ[1] = 8'd3; circ[2] = 8'd1; circ[3] = 8'd1;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(s[8*(4*c+j) +: 8], circ[(j - row + 4) % 4]);
            r[8*(4*c+row) +: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bus(input string tag, input logic a,
                          input logic [WORD_W-1:0] w);
      bus.addr      = a;
      bus.inp_demux = w;
      #1;
      chk({tag, "_flags"}, 128'(bus.outp_flags),
          a ? 128'd0 : 128'(w[NFLAGS-1:0]));
      chk({tag, "_data"}, 128'(bus.outp_data),
          a ? 128'(w) : 128'd0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [127:0] exp_ark, exp_mc, held;
   logic         rst_bit;

   initial begin
      resetn    = 1'b0;
      wr_en_mC  = 1'b1;
      inp_addRK = 128'h1;
      inp_key   = 128'h2;
      inp_mC    = 128'h3;
      bus.addr      = 1'b0;
      bus.inp_demux = '0;
      tick();
      chk("rst_ark", outp_addRK, 128'd0);
      chk("rst_mc", outp_mC, 128'd0);

      chk_bus("demux0", 1'b0, 32'hDEADBE01);
      chk_bus("demux1", 1'b1, 32'hDEADBE01);

      resetn    = 1'b1;
      inp_addRK = 128'h00112233445566778899aabbccddeeff;
      inp_key   = 128'h000102030405060708090a0b0c0d0e0f;
      inp_mC    = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
      wr_en_mC  = 1'b1;
      tick();
      chk("ark_vec", outp_addRK, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("mc_vec", outp_mC, 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e);
      chk("mc_model", mix_ref(inp_mC), outp_mC);

      held     = outp_mC;
      wr_en_mC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inp_mC = rnd128();
         tick();
         chk("mc_hold", outp_mC, held);
      end

      inp_mC   = {4{32'hc6c6c6c6}};
      wr_en_mC = 1'b1;
      tick();
      chk("mc_ident", outp_mC, {4{32'hc6c6c6c6}});

      exp_mc = outp_mC;
      for (int i = 0; i < 60; i++) begin
         rst_bit   = ($urandom_range(0, 7) != 0);
         resetn    = rst_bit;
         wr_en_mC  = $urandom_range(0, 1);
         inp_addRK = rnd128();
         inp_key   = rnd128();
         inp_mC    = rnd128();
         chk_bus("rnd_bus", $urandom_range(0, 1), $urandom);
         exp_ark = rst_bit ? (inp_addRK ^ inp_key) : 128'd0;
         if (!rst_bit)      exp_mc = 128'd0;
         else if (wr_en_mC) exp_mc = mix_ref(inp_mC);
         tick();
         chk("rnd_ark", outp_addRK, exp_ark);
         chk("rnd_mc", outp_mC, exp_mc);
      end

      resetn    = 1'b0;
      wr_en_mC  = 1'b1;
      inp_addRK = rnd128() | 128'h1;
      inp_key   = ~inp_addRK;
      inp_mC    = rnd128() | 128'h1;
      tick();
      chk("rst2_ark", outp_addRK, 128'd0);
      chk("rst2_mc", outp_mC, 128'd0);
      resetn = 1'b1;
      tick();
      chk("rel_ark", outp_addRK, {128{1'b1}});
      chk("rel_mc", outp_mC, mix_ref(inp_mC));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
